// File: rtl/decim_tdm.sv
// decim_tdm: TDM multi-channel frame decimator with FWFT output FIFO.
// Ports: clk/rstn, en, in_valid/in_data/in_sop, cfg_ratio/cfg_phase, clr_ovf, out_valid/out_ready/out_data/out_ch, ovf, sop_err, level.
module decim_tdm #(
  parameter int DW = 21,
  parameter int NCH = 4,
  parameter int RW = 4,
  parameter int DEPTH = 4,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           en,
  input  logic           in_valid,
  input  logic [DW-1:0]  in_data,
  input  logic           in_sop,
  input  logic [RW-1:0]  cfg_ratio,
  input  logic [RW-1:0]  cfg_phase,
  input  logic           clr_ovf,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_data,
  output logic [CHW-1:0] out_ch,
  output logic           ovf,
  output logic           sop_err,
  output logic [LW-1:0]  level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CHW-1:0] CH_LAST = CHW'(NCH - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic           accept;
  logic           boundary;
  logic           grp_end;
  logic           keep;
  logic           pop;
  logic           full;
  logic           wr_ok;
  logic           drop;
  logic [CHW-1:0] ch_cnt;
  logic [CHW-1:0] ch_eff;
  logic [CHW-1:0] ch_nxt;
  logic [RW-1:0]  frame_cnt;
  logic [RW-1:0]  ratio_s;
  logic [RW-1:0]  phase_s;
  logic [RW-1:0]  phase_ld;
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [DW-1:0]  mem_d [DEPTH];
  logic [CHW-1:0] mem_c [DEPTH];

  assign accept = en & in_valid;

  // sop forces channel 0 for this sample and realigns the counter
  assign ch_eff = in_sop ? '0 : ch_cnt;
  assign ch_nxt = (ch_eff == CH_LAST) ? '0 : ch_eff + 1'b1;

  assign boundary = accept & (ch_eff == CH_LAST);
  assign grp_end  = boundary & (frame_cnt == ratio_s);
  assign keep     = accept & (frame_cnt == phase_s);

  assign phase_ld = (cfg_phase > cfg_ratio) ? cfg_ratio : cfg_phase;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ch_cnt    <= '0;
      frame_cnt <= '0;
      ratio_s   <= RW'(4);
      phase_s   <= RW'(4);
      sop_err   <= 1'b0;
    end else begin
      sop_err <= accept & in_sop & (ch_cnt != '0);
      if (accept) begin
        ch_cnt <= ch_nxt;
      end
      if (grp_end) begin
        frame_cnt <= '0;
        ratio_s   <= cfg_ratio;
        phase_s   <= phase_ld;
      end else if (boundary) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign out_valid = (level != '0);
  assign pop       = out_valid & out_ready;
  assign full      = (level == LVL_FULL);
  // a same-cycle pop frees the slot, so a full FIFO still takes the push
  assign wr_ok     = keep & (~full | pop);
  assign drop      = keep & full & ~pop;

  assign out_data = mem_d[rd_ptr];
  assign out_ch   = mem_c[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] <= '0;
        mem_c[i] <= '0;
      end
    end else begin
      if (wr_ok) begin
        mem_d[wr_ptr] <= in_data;
        mem_c[wr_ptr] <= ch_eff;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({wr_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (drop) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule
